// File: rtl/uart_rx_dram_writer_if.sv
// DRAM write port driven by the UART receiver: byte, address, one-cycle strobe.
interface uart_rx_dram_writer_if #(
    parameter int ADDR_W = 16
);
    logic [7:0]        data_out;
    logic [ADDR_W-1:0] address_out;
    logic              wren;

    modport master (output data_out, output address_out, output wren);
    modport slave  (input  data_out, input  address_out, input  wren);
endinterface

// File: rtl/uart_rx_dram_writer.sv
// 8N1 UART receiver writing each good byte to DRAM at an auto-incrementing address.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_rx_dram_writer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    uart_rx_dram_writer_if.master    dram,
    output logic                     rx_busy,
    output logic                     frame_err,
    output logic                     parity_err,
    output logic [2:0]               state_out
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    logic              rx_meta_q, rx_s_q, rx_prev_q;
    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wren_q, wren_d;
    logic              ferr_q, ferr_d;
    logic              perr_q, perr_d;
    logic              cnt_last;
    logic              par_bad;
`ifdef UART_RX_PARITY_EN
    logic              par_q, par_d;
`endif

    assign cnt_last = (cnt_q == CNT_LAST);
`ifdef UART_RX_PARITY_EN
    assign par_bad = par_q ^ (^shift_q);
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wren_d  = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                // Strobe cycle: address advances only after the write is seen.
                if (wren_q) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_last) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_HIGH;
                    end else if (par_bad) begin
                        perr_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        data_d = shift_q;
                        wren_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            wren_q    <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            wren_q    <= wren_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign dram.data_out    = data_q;
    assign dram.address_out = addr_q;
    assign dram.wren        = wren_q;
    assign rx_busy          = (state_q != ST_IDLE);
    assign frame_err        = ferr_q;
    assign parity_err       = perr_q;
    assign state_out        = state_q;
endmodule

// File: tb/tb_uart_rx_dram_writer.sv
// Scoreboard bench for uart_rx_dram_writer; parity scenario runs when
// UART_RX_PARITY_EN is defined.
module tb_uart_rx_dram_writer;
    localparam int CPB = 16;
    localparam int AW  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rx_busy, frame_err, parity_err;
    logic [2:0] state_out;

    always #5 clk = ~clk;

    uart_rx_dram_writer_if #(.ADDR_W(AW)) dram ();

    uart_rx_dram_writer #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .dram      (dram),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .state_out (state_out)
    );

    typedef struct {
        logic [7:0]    d;
        logic [AW-1:0] a;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    logic [AW-1:0] exp_addr = '0;
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            wr_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
    int            wren_cyc = 0, start_cyc = 0;
    logic          wren_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: pops one expected write per strobe cycle
    always @(negedge clk) begin
        if (dram.wren) begin
            wr_cnt++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: data=%h addr=%h, required no write",
                         dram.data_out, dram.address_out);
            end else begin
                e = sb.pop_front();
                if ({dram.data_out, dram.address_out} !== {e.d, e.a}) begin
                    bad++;
                    $display("FAIL write: data=%h addr=%h, required data=%h addr=%h",
                             dram.data_out, dram.address_out, e.d, e.a);
                end
            end
            total++;
            if (wren_prev) begin
                bad++;
                $display("FAIL wren_width: wren high 2+ cycles, required 1");
            end else begin
                wren_cyc = cyc;
            end
        end
        if (frame_err)  ferr_cnt++;
        if (parity_err) perr_cnt++;
        wren_prev = dram.wren;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        start_cyc = cyc + 1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^b);
`endif
        send_bit(stop_bit);
    endtask

    task automatic expect_write(input logic [7:0] b);
        sb.push_back('{d: b, a: exp_addr});
        exp_addr = exp_addr + 1'b1;
    endtask

    task automatic check_sb_empty(input string name);
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL %s: %0d expected writes missing, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        int w0;
        rst = 1'b1;
        rx  = 1'b1;
        idle(2);
        rst = 1'b0;
        exp_addr = '0;
        total++;
        if ({state_out, rx_busy, frame_err, parity_err, dram.wren} !== 7'd0) begin
            bad++;
            $display("FAIL reset_flags: st=%0d busy=%b ferr=%b perr=%b wren=%b, required 0",
                     state_out, rx_busy, frame_err, parity_err, dram.wren);
        end
        total++;
        if (dram.data_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_data: %h, required 00", dram.data_out);
        end
        total++;
        if (dram.address_out !== '0) begin
            bad++;
            $display("FAIL reset_addr: %h, required 0", dram.address_out);
        end
        w0 = wr_cnt;
        idle(100);
        total++;
        if (wr_cnt !== w0 || state_out !== 3'd0) begin
            bad++;
            $display("FAIL reset_idle: writes=%0d st=%0d, required 0 and 0",
                     wr_cnt - w0, state_out);
        end
    endtask

    task automatic test_two_frames;
        logic [7:0] bytes [2];
        int lat;
        bytes[0] = 8'hA5;
        bytes[1] = 8'h3C;
        for (int i = 0; i < 2; i++) begin
            expect_write(bytes[i]);
            send_frame(bytes[i], 1'b1);
            lat = wren_cyc - start_cyc;
            total++;
            if (lat < 150 || lat > 154) begin
                bad++;
                $display("FAIL latency_%0d: %0d cycles, required 152+-2", i, lat);
            end
        end
        idle(20);
        check_sb_empty("two_frames");
        total++;
        if (dram.data_out !== 8'h3C || dram.address_out !== 4'd2) begin
            bad++;
            $display("FAIL hold: data=%h addr=%h, required 3c and 2",
                     dram.data_out, dram.address_out);
        end
    endtask

    task automatic test_glitch;
        int w0, f0;
        w0 = wr_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        idle(4);
        total++;
        if (state_out !== 3'd1 || rx_busy !== 1'b1) begin
            bad++;
            $display("FAIL glitch_start: st=%0d busy=%b, required 1 and 1", state_out, rx_busy);
        end
        rx = 1'b1;
        idle(40);
        total++;
        if (state_out !== 3'd0 || wr_cnt !== w0 || ferr_cnt !== f0 ||
            dram.address_out !== exp_addr) begin
            bad++;
            $display("FAIL glitch: st=%0d writes=%0d ferr=%0d addr=%h, required 0 0 0 %h",
                     state_out, wr_cnt - w0, ferr_cnt - f0, dram.address_out, exp_addr);
        end
    endtask

    task automatic test_break;
        int w0, f0, p0;
        w0 = wr_cnt;
        f0 = ferr_cnt;
        p0 = perr_cnt;
        send_frame(8'h55, 1'b0);
        idle(40);
        total++;
        if (ferr_cnt !== f0 + 1 || perr_cnt !== p0 || wr_cnt !== w0) begin
            bad++;
            $display("FAIL break_err: ferr=%0d perr=%0d writes=%0d, required 1 0 0",
                     ferr_cnt - f0, perr_cnt - p0, wr_cnt - w0);
        end
        total++;
        if (state_out !== 3'd5) begin
            bad++;
            $display("FAIL break_state: st=%0d, required 5", state_out);
        end
        rx = 1'b1;
        idle(10);
        total++;
        if (state_out !== 3'd0) begin
            bad++;
            $display("FAIL break_release: st=%0d, required 0", state_out);
        end
        expect_write(8'h12);
        send_frame(8'h12, 1'b1);
        idle(20);
        check_sb_empty("break_next");
    endtask

    task automatic test_reset_mid_frame;
        int w0;
        w0 = wr_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        rx = 1'b1;
        idle(8);
        total++;
        if (state_out !== 3'd2) begin
            bad++;
            $display("FAIL midreset_data: st=%0d, required 2", state_out);
        end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_addr = '0;
        idle(200);
        total++;
        if (wr_cnt !== w0 || dram.address_out !== '0 || state_out !== 3'd0) begin
            bad++;
            $display("FAIL midreset: writes=%0d addr=%h st=%0d, required 0 0 0",
                     wr_cnt - w0, dram.address_out, state_out);
        end
        expect_write(8'h99);
        send_frame(8'h99, 1'b1);
        idle(20);
        check_sb_empty("midreset_next");
    endtask

    task automatic test_back_to_back_wrap;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_addr = '0;
        for (int i = 0; i < 17; i++) begin
            expect_write(8'(i));
            send_frame(8'(i), 1'b1);
        end
        idle(20);
        check_sb_empty("wrap");
        total++;
        if (dram.address_out !== 4'd1 || dram.data_out !== 8'h10) begin
            bad++;
            $display("FAIL wrap_final: addr=%h data=%h, required 1 and 10",
                     dram.address_out, dram.data_out);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] b, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(1'b1);
    endtask

    task automatic test_parity;
        int w0, p0;
        w0 = wr_cnt;
        p0 = perr_cnt;
        send_frame_par(8'h03, 1'b1);
        idle(20);
        total++;
        if (perr_cnt !== p0 + 1 || wr_cnt !== w0) begin
            bad++;
            $display("FAIL parity_bad: perr=%0d writes=%0d, required 1 and 0",
                     perr_cnt - p0, wr_cnt - w0);
        end
        expect_write(8'h03);
        send_frame_par(8'h03, 1'b0);
        idle(20);
        check_sb_empty("parity_good");
        total++;
        if (perr_cnt !== p0 + 1) begin
            bad++;
            $display("FAIL parity_good_err: perr=%0d, required 1", perr_cnt - p0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_two_frames();
        test_glitch();
        test_break();
        test_reset_mid_frame();
        test_back_to_back_wrap();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
